// File: rtl/ram_responder_pkg.sv
// ============================================================================
// Module : ram_responder_pkg
// Brief  : Shared types for the cache<->RAM responder and its word store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DONE = 2'd2,
        R_ERR  = 2'd3
    } resp_state_t;

    localparam int RAM_LAT_W = 4;

    function automatic ramstate_t to_ramstate(input resp_state_t s);
        case (s)
            R_WAIT:  return BUSY;
            R_DONE:  return ACCESS;
            R_ERR:   return ERROR;
            default: return FREE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_responder_if.sv
// ============================================================================
// Module : ram_responder_if
// Brief  : Request/response bundle between a requester and the RAM responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_responder_if;
    import ram_responder_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

`default_nettype wire

// File: rtl/ram_responder_store.sv
// ============================================================================
// Module : ram_store
// Brief  : Word array with one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_store
    import ram_responder_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    input  wire logic               we_i,
    input  wire logic               re_i,
    input  wire logic [DEPTH_W-1:0] idx_i,
    input  wire word_t              wdata_i,
    output word_t                   rdata_o
);

    word_t mem_q [2**DEPTH_W];
    word_t rdata_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 2**DEPTH_W; k++) begin
                mem_q[k] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// ============================================================================
// Module : ram_responder
// Brief  : Memory-side responder: latency-timed word reads/writes, FREE/BUSY/
//          ACCESS/ERROR status decoded from the state register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int LAT     = 2,
    parameter int DEPTH_W = 8
) (
    input wire logic        CLK,
    input wire logic        RST,
    ram_responder_if.slave  bus
);

    localparam logic [RAM_LAT_W-1:0] LAT_C = RAM_LAT_W'(LAT);

    resp_state_t          state_q;
    logic [RAM_LAT_W-1:0] cnt_q;
    word_t                addr_q;
    word_t                store_q;
    logic                 wen_q;

    logic               w_req;
    logic               w_illegal;
    logic               w_changed;
    logic               w_exec;
    logic               w_is_wr;
    word_t              w_addr;
    word_t              w_wdata;
    logic [DEPTH_W-1:0] w_idx;

    assign w_req     = bus.ramREN | bus.ramWEN;
    assign w_illegal = (bus.ramREN & bus.ramWEN)
                     | (bus.ramaddr[1:0] != 2'b00)
                     | (bus.ramaddr[31:DEPTH_W+2] != '0);
    assign w_changed = (bus.ramaddr != addr_q) | (bus.ramWEN != wen_q)
                     | (bus.ramstore != store_q);

    // Zero latency executes straight from IDLE using the live request.
    assign w_exec = w_req & ~w_illegal &
                    (((state_q == R_IDLE) && (LAT == 0)) ||
                     ((state_q == R_WAIT) && !w_changed && (cnt_q == 4'd1)));

    assign w_is_wr = (state_q == R_IDLE) ? bus.ramWEN   : wen_q;
    assign w_addr  = (state_q == R_IDLE) ? bus.ramaddr  : addr_q;
    assign w_wdata = (state_q == R_IDLE) ? bus.ramstore : store_q;
    assign w_idx   = w_addr[DEPTH_W+1:2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            state_q <= R_ERR;
                        end else begin
                            addr_q  <= bus.ramaddr;
                            store_q <= bus.ramstore;
                            wen_q   <= bus.ramWEN;
                            cnt_q   <= LAT_C;
                            state_q <= (LAT == 0) ? R_DONE : R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    // A request that turns illegal mid-wait is reported, not executed.
                    if (!w_req) begin
                        state_q <= R_IDLE;
                    end else if (w_illegal) begin
                        state_q <= R_ERR;
                    end else if (w_changed) begin
                        addr_q  <= bus.ramaddr;
                        store_q <= bus.ramstore;
                        wen_q   <= bus.ramWEN;
                        cnt_q   <= LAT_C;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= R_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                end
            endcase
        end
    end

    ram_store #(
        .DEPTH_W (DEPTH_W)
    ) u_store (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (w_exec & w_is_wr),
        .re_i    (w_exec & ~w_is_wr),
        .idx_i   (w_idx),
        .wdata_i (w_wdata),
        .rdata_o (bus.ramload)
    );

    assign bus.ramstate = to_ramstate(state_q);

endmodule

`default_nettype wire
